// File: rtl/ssd_scan_decoder_if.sv
// Scan-bus bundle between a seven-segment display driver and its monitor.
//   Anode    : digit enables, active-low, [0]=ones .. [3]=thousands
//   ssd_out  : segments, active-low, {a,b,c,d,e,f,g}, a at bit 6
//   o_digits : captured BCD digits {thousands,hundreds,tens,ones}
//   o_value  : binary value 0..9999 of the last emitted frame
//   o_valid  : one-cycle pulse when o_value/o_err update
//   o_err    : frame contained an undecodable segment pattern
// master drives the scan bus; slave is the decoder.
interface ssd_scan_decoder_if;
  logic [3:0]  Anode;
  logic [6:0]  ssd_out;
  logic [15:0] o_digits;
  logic [13:0] o_value;
  logic        o_valid;
  logic        o_err;

  modport master (
    output Anode, ssd_out,
    input  o_digits, o_value, o_valid, o_err
  );

  modport slave (
    input  Anode, ssd_out,
    output o_digits, o_value, o_valid, o_err
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for a multiplexed four-digit seven-segment bus.
// Reconstructs the displayed decimal value from stable anode dwells and
// emits one registered value plus a valid strobe per complete scan.
// Ports:
//   fastclock : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : ssd_scan_decoder_if.slave (Anode/ssd_out in, o_* out)
// Parameter:
//   STABLE_CYCLES : cycles an anode pattern must hold before capture (1..255)
// Build option:
//   SSD_SCAN_CONFIRM_EN : only emit a frame that repeats the previous
//                         clean frame; o_err is then always 0.
module ssd_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic               fastclock,
  input logic               rst_n,
  ssd_scan_decoder_if.slave bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned VAL_W = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [3:0]       an_q, an_prev_q;
  logic [6:0]       seg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       seen_q, bad_q, bad_d;
  logic [15:0]      digits_q, digits_d, snap_q;
  logic             snap_bad_q, emit_q;
  logic [VAL_W-1:0] value_q, value_c;
  logic             valid_q, err_q;
  logic             legal_c, changed_c, capture_c, complete_c;
  logic [DIG_W-1:0] dec_c;
  logic             dec_bad_c;
`ifdef SSD_SCAN_CONFIRM_EN
  logic [15:0]      prev_q;
  logic             prev_bad_q;
`endif

  // Exactly one active-low enable is a legal digit select
  always_comb begin
    legal_c = 1'b0;
    case (an_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal_c = 1'b1;
      default:                            legal_c = 1'b0;
    endcase
  end

  // Active-low segment decode; blank reads as 0 for leading blanking
  always_comb begin
    dec_c     = 4'hF;
    dec_bad_c = 1'b0;
    case (seg_q)
      7'h01, 7'h7F: dec_c = 4'd0;
      7'h4F:        dec_c = 4'd1;
      7'h12:        dec_c = 4'd2;
      7'h06:        dec_c = 4'd3;
      7'h4C:        dec_c = 4'd4;
      7'h24:        dec_c = 4'd5;
      7'h20:        dec_c = 4'd6;
      7'h0F:        dec_c = 4'd7;
      7'h00:        dec_c = 4'd8;
      7'h04:        dec_c = 4'd9;
      default:      dec_bad_c = 1'b1;
    endcase
  end

  // Dwell counter; capture fires once, on the cycle the count reaches the limit
  always_comb begin
    changed_c = (an_q != an_prev_q);
    cnt_d     = '0;
    if (legal_c) begin
      if (changed_c)            cnt_d = CNT_W'(1);
      else if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      else                      cnt_d = cnt_q;
    end
    capture_c  = legal_c && (cnt_d == CNT_MAX) && (changed_c || (cnt_q != CNT_MAX));
    complete_c = capture_c && ((seen_q | ~an_q) == 4'hF);
  end

  // Slot write for the selected digit; a recapture overwrites digit and bad flag
  always_comb begin
    digits_d = digits_q;
    bad_d    = bad_q;
    for (int i = 0; i < 4; i++) begin
      if (capture_c && !an_q[i]) begin
        digits_d[i*DIG_W +: DIG_W] = dec_c;
        bad_d[i]                   = dec_bad_c;
      end
    end
  end

  // BCD snapshot to binary; max 9999 fits in 14 bits
  always_comb begin
    value_c = VAL_W'(snap_q[15:12]) * VAL_W'(1000)
            + VAL_W'(snap_q[11:8])  * VAL_W'(100)
            + VAL_W'(snap_q[7:4])   * VAL_W'(10)
            + VAL_W'(snap_q[3:0]);
  end

  always_ff @(posedge fastclock or negedge rst_n) begin
    if (!rst_n) begin
      an_q       <= 4'hF;
      an_prev_q  <= 4'hF;
      seg_q      <= 7'h7F;
      cnt_q      <= '0;
      seen_q     <= '0;
      bad_q      <= '0;
      digits_q   <= '0;
      snap_q     <= '0;
      snap_bad_q <= 1'b0;
      emit_q     <= 1'b0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef SSD_SCAN_CONFIRM_EN
      prev_q     <= '0;
      prev_bad_q <= 1'b1;  // no earlier frame to confirm against after reset
`endif
    end else begin
      an_q      <= bus.Anode;
      seg_q     <= bus.ssd_out;
      an_prev_q <= an_q;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      emit_q    <= complete_c;

      if (complete_c) begin
        seen_q     <= '0;
        bad_q      <= '0;
        snap_q     <= digits_d;
        snap_bad_q <= |bad_d;
      end else if (capture_c) begin
        seen_q <= seen_q | ~an_q;
        bad_q  <= bad_d;
      end

      // Emission one edge after the completing capture
      valid_q <= 1'b0;
`ifdef SSD_SCAN_CONFIRM_EN
      if (emit_q) begin
        if (!snap_bad_q && !prev_bad_q && (snap_q == prev_q)) begin
          valid_q <= 1'b1;
          value_q <= value_c;
        end
        prev_q     <= snap_q;
        prev_bad_q <= snap_bad_q;
      end
`else
      if (emit_q) begin
        valid_q <= 1'b1;
        err_q   <= snap_bad_q;
        value_q <= snap_bad_q ? '0 : value_c;
      end
`endif
    end
  end

  assign bus.o_digits = digits_q;
  assign bus.o_value  = value_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench for ssd_scan_decoder: directed scans plus randomized
// scans with glitches, illegal anodes, bad codes and recaptures, checked
// every cycle against a run-length reference model of the scan rules.
module tb_ssd_scan_decoder;
  localparam int unsigned S    = 4;
  localparam int          MAXE = 16384;
`ifdef SSD_SCAN_CONFIRM_EN
  localparam bit CONFIRM = 1'b1;
`else
  localparam bit CONFIRM = 1'b0;
`endif

  logic fastclock = 1'b0;
  logic rst_n     = 1'b0;

  ssd_scan_decoder_if bus ();

  ssd_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .fastclock (fastclock),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 fastclock = ~fastclock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected-event timeline indexed by clock edge number
  int          edge_n = 0;
  bit          exp_vld [MAXE];
  logic [13:0] exp_val [MAXE];
  bit          exp_err [MAXE];
  bit          dig_upd [MAXE];
  logic [15:0] dig_new [MAXE];

  logic [6:0] codes [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                             7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  logic [3:0] ill   [5]  = '{4'hF, 4'b0011, 4'b0000, 4'b1001, 4'b0101};

  // Reference model state: pin-level run tracking and frame bookkeeping
  logic [3:0]  run_an = 4'hF;
  int unsigned run_len = 0;
  logic [3:0]  m_dig [4];
  bit          m_bad [4];
  logic [3:0]  m_seen = 4'h0;
  logic [15:0] m_prev = 16'h0;
  bit          m_prev_bad = 1'b1;
  logic [15:0] cur_dig = 16'h0;
  bit          mon_en = 1'b0;
  int          obs_pulses = 0;
  int          exp_pulses = 0;

  always @(posedge fastclock) edge_n++;

  function automatic void decode(input logic [6:0] seg, output logic [3:0] d, output bit bad);
    d   = 4'hF;
    bad = 1'b1;
    if (seg == 7'h7F) begin d = 4'd0; bad = 1'b0; end
    for (int k = 0; k < 10; k++)
      if (codes[k] == seg) begin d = 4'(k); bad = 1'b0; end
  endfunction

  // Pins (an,seg) are sampled at edge e
  function automatic void model_step(input logic [3:0] an, input logic [6:0] seg, input int e);
    logic [3:0]  d;
    bit          bad, fbad;
    logic [15:0] fd;
    int          slot, v;
    if (an == run_an) run_len++;
    else begin run_an = an; run_len = 1; end
    if ($countones(~an) == 1 && run_len == S && e + 2 < MAXE) begin
      slot = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) slot = i;
      decode(seg, d, bad);
      m_dig[slot]  = d;
      m_bad[slot]  = bad;
      m_seen[slot] = 1'b1;
      fd = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      dig_upd[e+1] = 1'b1;
      dig_new[e+1] = fd;
      if (m_seen == 4'hF) begin
        fbad = m_bad[0] | m_bad[1] | m_bad[2] | m_bad[3];
        v = 1000*int'(fd[15:12]) + 100*int'(fd[11:8]) + 10*int'(fd[7:4]) + int'(fd[3:0]);
        m_seen = 4'h0;
        for (int i = 0; i < 4; i++) m_bad[i] = 1'b0;
        if (CONFIRM) begin
          if (!fbad && !m_prev_bad && fd == m_prev) begin
            exp_vld[e+2] = 1'b1; exp_val[e+2] = 14'(v); exp_err[e+2] = 1'b0;
          end
          m_prev     = fd;
          m_prev_bad = fbad;
        end else begin
          exp_vld[e+2] = 1'b1;
          exp_val[e+2] = fbad ? 14'd0 : 14'(v);
          exp_err[e+2] = fbad;
        end
      end
    end
  endfunction

  // Per-cycle comparison against the model timeline
  always @(negedge fastclock) begin
    if (mon_en && edge_n < MAXE) begin
      if (dig_upd[edge_n]) cur_dig = dig_new[edge_n];
      check("valid", 32'(bus.o_valid), 32'(exp_vld[edge_n]));
      if (exp_vld[edge_n]) begin
        exp_pulses++;
        check("value", 32'(bus.o_value), 32'(exp_val[edge_n]));
        check("err", 32'(bus.o_err), 32'(exp_err[edge_n]));
      end
      check("digits", 32'(bus.o_digits), 32'(cur_dig));
      if (bus.o_valid) obs_pulses++;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge fastclock);
      bus.Anode   = an;
      bus.ssd_out = seg;
      model_step(an, seg, edge_n + 1);
    end
  endtask

  task automatic idle(input int len);
    drive(4'hF, 7'h7F, len);
  endtask

  task automatic scan(input logic [6:0] c3, input logic [6:0] c2,
                      input logic [6:0] c1, input logic [6:0] c0, input int len);
    drive(4'b0111, c3, len);
    drive(4'b1011, c2, len);
    drive(4'b1101, c1, len);
    drive(4'b1110, c0, len);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  32'(bus.o_valid),  32'd0);
    check({tag, "_value"},  32'(bus.o_value),  32'd0);
    check({tag, "_err"},    32'(bus.o_err),    32'd0);
    check({tag, "_digits"}, 32'(bus.o_digits), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge fastclock);
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    bus.Anode   = 4'hF;
    bus.ssd_out = 7'h7F;
    for (int e = edge_n + 1; e < MAXE; e++) begin
      exp_vld[e] = 1'b0;
      dig_upd[e] = 1'b0;
    end
    run_an = 4'hF; run_len = 0; m_seen = 4'h0;
    for (int i = 0; i < 4; i++) begin m_dig[i] = 4'h0; m_bad[i] = 1'b0; end
    m_prev = 16'h0; m_prev_bad = 1'b1; cur_dig = 16'h0;
    #1 check_reset_outputs("rst_async");
    repeat (cycles) @(negedge fastclock);
    check_reset_outputs("rst_hold");
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int          seg_start;
    int          ord [4];
    int          j, t, slot;
    logic [3:0]  an;
    logic [6:0]  seg;

    bus.Anode   = 4'hF;
    bus.ssd_out = 7'h7F;
    for (int i = 0; i < 4; i++) begin m_dig[i] = 4'h0; m_bad[i] = 1'b0; end

    do_reset(3);

    // Value 49, two full scans
    scan(7'h01, 7'h01, 7'h4C, 7'h04, 8);
    scan(7'h01, 7'h01, 7'h4C, 7'h04, 8);
    idle(4);
    check("v49_value",  32'(bus.o_value),  32'd49);
    check("v49_digits", 32'(bus.o_digits), 32'h0049);
    check("v49_err",    32'(bus.o_err),    32'd0);

    // Leading blanking
    scan(7'h7F, 7'h7F, 7'h4C, 7'h04, 8);
    idle(4);
    check("blank_value",  32'(bus.o_value),  32'd49);
    check("blank_digits", 32'(bus.o_digits), 32'h0049);

    // Short hundreds pulse carrying 8 between tens and ones of 1234
    drive(4'b0111, 7'h4F, 8);
    drive(4'b1011, 7'h12, 8);
    drive(4'b1101, 7'h06, 8);
    drive(4'b1011, 7'h00, 3);
    drive(4'b1110, 7'h4C, 8);
    idle(4);
    check("glitch_digits", 32'(bus.o_digits), 32'h1234);
    check("glitch_value",  32'(bus.o_value),  CONFIRM ? 32'd49 : 32'd1234);

    // Illegal two-low anode, then 9999 with a bad tens code
    drive(4'b0011, 7'h00, 10);
    check("illegal_digits", 32'(bus.o_digits), 32'h1234);
    scan(7'h04, 7'h04, 7'h55, 7'h04, 8);
    idle(4);
    check("bad_digits", 32'(bus.o_digits), 32'h99F9);
    check("bad_value",  32'(bus.o_value),  CONFIRM ? 32'd49 : 32'd0);
    check("bad_err",    32'(bus.o_err),    CONFIRM ? 32'd0 : 32'd1);

    // Reset after two captured digits, then scan 0007
    drive(4'b0111, 7'h4F, 8);
    drive(4'b1011, 7'h12, 8);
    do_reset(1);
    scan(7'h01, 7'h01, 7'h01, 7'h0F, 8);
    idle(4);
    check("rstmid_digits", 32'(bus.o_digits), 32'h0007);
    check("rstmid_value",  32'(bus.o_value),  CONFIRM ? 32'd0 : 32'd7);

    // 5678 twice then 5679
    seg_start = obs_pulses;
    scan(7'h24, 7'h20, 7'h0F, 7'h00, 8);
    scan(7'h24, 7'h20, 7'h0F, 7'h00, 8);
    scan(7'h24, 7'h20, 7'h0F, 7'h04, 8);
    idle(4);
    check("confirm_pulses", 32'(obs_pulses - seg_start), CONFIRM ? 32'd1 : 32'd3);
    check("confirm_value",  32'(bus.o_value), CONFIRM ? 32'd5678 : 32'd5679);

    // Randomized scans
    for (int f = 0; f < 150; f++) begin
      for (int i = 0; i < 4; i++) ord[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        t = int'($urandom_range(0, 19));
        if (t == 0)      seg = 7'h7F;
        else if (t == 1) seg = 7'($urandom);
        else             seg = codes[$urandom_range(0, 9)];
        an = 4'hF;
        an[ord[i]] = 1'b0;
        drive(an, seg, int'($urandom_range(S, 12)));
        t = int'($urandom_range(0, 11));
        if (t == 0) begin
          an = 4'hF;
          an[$urandom_range(0, 3)] = 1'b0;
          drive(an, 7'($urandom), int'($urandom_range(1, S - 1)));
        end else if (t == 1) begin
          drive(ill[$urandom_range(0, 4)], 7'($urandom), int'($urandom_range(1, 6)));
        end else if (t == 2) begin
          slot = int'($urandom_range(0, 3));
          an = 4'hF;
          an[slot] = 1'b0;
          drive(an, codes[$urandom_range(0, 9)], int'($urandom_range(S, 9)));
        end
      end
    end
    idle(8);
    check("pulse_count", 32'(obs_pulses), 32'(exp_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Receive-side monitor for the multiplexed four-digit seven-segment bus: watches the `Anode`/`ssd_out` pair driven by the display driver and reconstructs the displayed decimal value. Sits beside the display driver on the `fastclock` domain. Gives the bench and on-chip self-check a registered binary value plus a frame-valid strobe for each complete, glitch-free scan of all four digits.

## Interface
- `STABLE_CYCLES`, default 4: consecutive `fastclock` cycles an anode pattern must hold before its digit is captured.
  - Legal range is 1..255.
- `fastclock` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `Anode` in 4: digit enables, active-low.
  - `Anode[0]` is ones, `Anode[3]` is thousands.
- `ssd_out` in 7: segments, active-low, `{a,b,c,d,e,f,g}` with `a` at bit 6.
- `o_digits` out 16: captured BCD digits, `{thousands,hundreds,tens,ones}`, 4 bits each.
- `o_value` out 14: binary value 0..9999 of the last emitted frame.
- `o_valid` out 1: one-cycle pulse when `o_value`/`o_err` update.
- `o_err` out 1: qualifies `o_valid`; the frame held an undecodable segment pattern.

## Operation
- **Input register.** `Anode`/`ssd_out` are registered once into `an_q`/`seg_q`. All logic below uses the registered copies.
- **Legal anode patterns.** `an_q` is legal only if exactly one bit is 0. Any other pattern (4'hF, two or more low) is illegal:
  - the dwell counter clears to 0;
  - no capture occurs.
- **Dwell counter.**
  - `an_q` legal and equal to its previous-cycle value: counter increments, saturating at `STABLE_CYCLES`.
  - `an_q` legal and different from the previous cycle: counter loads 1.
- **Capture.** Capture happens in the cycle the counter becomes exactly `STABLE_CYCLES`, so a dwell captures exactly once. A capture:
  - writes the decoded digit into the slot selected by `an_q`;
  - sets that slot's bit in a 4-bit `seen` mask.
- **Segment decode.** Standard active-low patterns for 0..9:
  - 7'h01=0, 7'h4F=1, 7'h12=2, 7'h06=3, 7'h4C=4, 7'h24=5, 7'h20=6, 7'h0F=7, 7'h00=8, 7'h04=9.
  - Blank (7'h7F) decodes to 0, covering leading blanking.
  - Any other pattern stores 4'hF and marks the slot bad.
- **Frame completion.** When a capture makes `seen` == 4'b1111:
  - `seen` and the bad flags clear;
  - the digit snapshot is latched for emission.
- **Emission.** On the following edge:
  - `o_value` = d3·1000 + d2·100 + d1·10 + d0, computed at 14 bits with no overflow possible;
  - `o_err` = OR of bad flags;
  - `o_valid` = 1 for one cycle.
  - If `o_err` = 1, then `o_value` = 0.
- **Recapture.** A slot captured twice within one frame keeps the newest digit; the second capture alone does not complete the frame.
- **Frame start after reset.** The first frame is whichever four slots complete first; there is no alignment to digit 0.

## Timing
- **Reset state.** All outputs 0, plus all internal registers: `seen`, counter, `an_q` = 4'hF, `seg_q` = 7'h7F.
- **Reset mid-frame.** Partial captures are discarded; no `o_valid` is issued.
- **Capture latency.** A digit's `o_digits` slot updates `STABLE_CYCLES`+1 edges after its anode pattern first appears on the pins.
- **Emission latency.** `o_valid` asserts one edge after the completing capture, i.e. `STABLE_CYCLES`+2 edges after the fourth digit's anode appears.
- **Back-to-back frames.** A capture in the `o_valid` cycle counts toward the next frame.
- **Glitch rejection.** A legal anode pattern held for fewer than `STABLE_CYCLES` cycles is ignored entirely.
- **Single-digit dwell.** With `STABLE_CYCLES`=1, every legal cycle following a pattern change captures.

## Configuration
- `SSD_SCAN_CONFIRM_EN` defined:
  - `o_valid` is emitted only when the completed frame's digits equal the previous completed frame's digits and neither frame is bad;
  - a bad or mismatching frame updates the comparison snapshot silently;
  - `o_err` is always 0.
- Undefined:
  - every completed frame emits `o_valid`, with `o_err` as specified above.

## Test plan
- **Value 49.** Scan 0,0,4,9 (codes 7'h01, 7'h01, 7'h4C, 7'h04) at 8 cycles per digit, `STABLE_CYCLES`=4.
  - Required: `o_value`=49, `o_digits`=16'h0049, `o_err`=0.
  - `o_valid` pulses once per full scan, 6 edges after the ones digit's anode appears.
- **Leading blanking.** Same scan with thousands/hundreds at 7'h7F.
  - Required: `o_value`=49.
- **Glitch rejection.** Insert a 3-cycle `Anode`=4'b1011 pulse carrying 7'h00 mid-scan of value 1234.
  - Required: no capture of 8; `o_value`=1234.
- **Illegal and bad patterns.** `Anode`=4'b0011 for 10 cycles causes no capture. Segment 7'h55 on tens in a scan of 9999.
  - Required: `o_valid`=1, `o_err`=1, `o_value`=0.
- **Reset mid-frame.** Capture two digits, pulse `rst_n` low for 1 cycle, then scan 0007.
  - Required: outputs 0 during reset; the first `o_valid` carries 7 only after all four digits are recaptured.
- **Confirm mode.** With `SSD_SCAN_CONFIRM_EN` defined, scan 5678 twice, then 5679 once.
  - Required: `o_valid` fires only on the second 5678 scan and not on the 5679 scan.
